com_spi_sched: RTL and testbench
================================

# com_spi_sched

Transaction scheduler that shares the single COM SPI controller engine (16-bit words, full duplex) between two requesters: channel 0, the host CSR path, and channel 1, the wirq-driven autoread path. It grants bursts round-robin and streams TX words into the engine through a go/done handshake. It holds chip-select across the words of a burst, enforces an inter-burst CS-high gap, and aborts a stuck word with a watchdog. It sits between the CSR/autoread logic and the SPI controller whose sclk/copi/cipo/csn drive the EC link.

## Interface
- WORD_W, 16: SPI word width.
- LEN_W, 4: burst-length field width; a burst carries 1..2^LEN_W-1 words.
- GAP_CYCLES, 4: minimum number of clk cycles with eng_hold low between bursts; must be ≥1.
- TIMEOUT, 1024: maximum number of clk cycles from eng_go to eng_done.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- ch_req  in  2  level request per channel.
- ch_len  in  2*LEN_W  burst length per channel; ch n uses bits [n*LEN_W +: LEN_W].
- ch_ack  out  2  one-cycle pulse; request and length accepted.
- ch_tx  in  2*WORD_W  TX word per channel.
- ch_tx_valid  in  2  TX word valid.
- ch_tx_ready  out  2  TX word accepted (granted channel only).
- rx_data  out  WORD_W  last received word; shared by both channels.
- rx_valid  out  2  one-cycle pulse per channel; rx_data is valid in that cycle.
- ch_done  out  2  one-cycle pulse at burst end.
- ch_err  out  2  one-cycle pulse, coincident with ch_done, when the burst was aborted by timeout.
- eng_tx  out  WORD_W  word to the engine, held stable until eng_done.
- eng_go  out  1  one-cycle start pulse.
- eng_hold  out  1  keeps CS asserted (low) across the words of a burst.
- eng_done  in  1  one-cycle pulse; word complete.
- eng_rx  in  WORD_W  received word, valid while eng_done=1.

## Operation
- FSM states: IDLE, LOAD, XFER, GAP.
- IDLE:
  - If any ch_req is high, grant one channel: round-robin; on a tie the channel other than the last grant wins. Last-grant resets to 1, so channel 0 wins first after reset.
  - Latch the grant index and ch_len, and pulse ch_ack.
  - len=0: pulse ch_done next cycle, no engine activity, no gap; stay in IDLE.
  - Otherwise go to LOAD.
- LOAD:
  - ch_tx_ready[g]=1.
  - On ch_tx_valid[g]: register the word into eng_tx, pulse eng_go the next cycle, go to XFER.
  - A TX stall holds the FSM in LOAD indefinitely, with eng_hold still high.
- XFER:
  - Watchdog counts up from 0 starting at the eng_go cycle.
  - On eng_done: capture eng_rx into rx_data, pulse rx_valid[g] the next cycle, decrement the remaining count.
  - If the remaining count is still >0, return to LOAD; if it reaches 0, pulse ch_done[g] with the last rx_valid and go to GAP.
- Timeout (counter reaches TIMEOUT-1 without eng_done):
  - Pulse ch_done[g] and ch_err[g], with no rx_valid.
  - Drop the remaining words and go to GAP.
- eng_done and timeout in the same cycle: done wins, no error.
- GAP: eng_hold=0 for GAP_CYCLES cycles, then return to IDLE.
- ch_req is sampled only in IDLE; deasserting it mid-burst does not cancel the burst.
- eng_done outside XFER is ignored.
- Remaining-word counter is LEN_W bits; it never wraps because len=0 is handled in IDLE.

## Timing
- Reset values: ch_ack, ch_tx_ready, rx_valid, ch_done, ch_err, eng_go, eng_hold = 0; rx_data, eng_tx = 0; FSM in IDLE.
- Reset mid-burst: all outputs reach their reset values at the next clk edge, with no ch_done. The engine is reset by the same rst_n.
- ch_req high in IDLE → ch_ack at edge +1 → earliest ch_tx_ready at +1 → earliest eng_go 1 cycle after the TX handshake.
- eng_hold rises with the ch_ack cycle and falls on entry to GAP.
- eng_done → rx_valid latency: 1 cycle. Back-to-back words: next eng_go no earlier than 2 cycles after eng_done.
- Burst end to next ch_ack: at least GAP_CYCLES+1 cycles.

## Structure
- Shared package com_spi_pkg holds:
  - FSM state enum.
  - WORD_W and LEN_W defaults.
  - Channel index constants: CH_HOST=0, CH_AUTO=1.
- One sub-module, com_spi_rr_arb: the 2-way round-robin arbiter (req, update enable, grant index, last-grant register).
- Watchdog and gap counters stay inline in com_spi_sched.

## Test plan
- Single word on channel 0, len=1, tx 0xA503, engine loopback model:
  - Exactly one eng_go.
  - rx_valid[0] with rx_data=0xA503, ch_done[0] in the same cycle.
  - eng_hold low ≥4 cycles afterwards.
- Both ch_req rise in the same cycle after reset, each len=1 → channel 0 granted first, channel 1 after the gap; no overlap of eng_hold.
- Channel 0 request held permanently with len=2, channel 1 pulsed in → grants alternate 0,1,0.
- Channel 1, len=3, tx 0x1111/0x2222/0x3333, ch_tx_valid low for 10 cycles before the second word:
  - Three eng_go pulses.
  - eng_hold continuously high.
  - rx sequence matches the TX words.
- Engine never asserts eng_done:
  - ch_done[0] and ch_err[0] exactly TIMEOUT cycles after eng_go.
  - FSM returns to IDLE after the gap.
- rst_n low during XFER of word 2 of 3 → all outputs 0 at the next edge, no ch_done. A fresh request after reset completes normally.

Source files
------------

// File: rtl/com_spi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : com_spi_pkg                                                   |
// | Purpose  : Shared types and constants for the COM SPI transaction        |
// |            scheduler: FSM state encoding, default word/length widths,    |
// |            channel index constants and a channel one-hot helper.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package com_spi_pkg;

    localparam int DEF_WORD_W = 16;
    localparam int DEF_LEN_W  = 4;

    // Requester channel indices
    localparam int CH_HOST = 0;
    localparam int CH_AUTO = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_XFER = 2'd2,
        ST_GAP  = 2'd3
    } sched_state_t;

    // One-hot per-channel strobe vector for a channel index
    function automatic logic [1:0] ch_onehot(input logic idx);
        return (idx == 1'(CH_AUTO)) ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/com_spi_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : com_spi_sched_if                                              |
// | Purpose  : Bundles the requester-side and engine-side signals of the     |
// |            COM SPI scheduler.                                            |
// |   Requester side: ch_req, ch_len, ch_ack, ch_tx, ch_tx_valid,            |
// |                   ch_tx_ready, rx_data, rx_valid, ch_done, ch_err        |
// |   Engine side   : eng_tx, eng_go, eng_hold, eng_done, eng_rx             |
// |   Modports      : slave  - the scheduler                                 |
// |                   master - the requesters plus SPI engine around it      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface com_spi_sched_if #(
    parameter int WORD_W = 16,
    parameter int LEN_W  = 4
) ();

    logic [1:0]          ch_req;
    logic [2*LEN_W-1:0]  ch_len;
    logic [1:0]          ch_ack;
    logic [2*WORD_W-1:0] ch_tx;
    logic [1:0]          ch_tx_valid;
    logic [1:0]          ch_tx_ready;
    logic [WORD_W-1:0]   rx_data;
    logic [1:0]          rx_valid;
    logic [1:0]          ch_done;
    logic [1:0]          ch_err;
    logic [WORD_W-1:0]   eng_tx;
    logic                eng_go;
    logic                eng_hold;
    logic                eng_done;
    logic [WORD_W-1:0]   eng_rx;

    modport slave (
        input  ch_req, ch_len, ch_tx, ch_tx_valid, eng_done, eng_rx,
        output ch_ack, ch_tx_ready, rx_data, rx_valid, ch_done, ch_err,
               eng_tx, eng_go, eng_hold
    );

    modport master (
        output ch_req, ch_len, ch_tx, ch_tx_valid, eng_done, eng_rx,
        input  ch_ack, ch_tx_ready, rx_data, rx_valid, ch_done, ch_err,
               eng_tx, eng_go, eng_hold
    );

endinterface
`default_nettype wire

// File: rtl/com_spi_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : com_spi_rr_arb                                                |
// | Purpose  : Two-way round-robin arbiter. On a tie the channel other than  |
// |            the last grant wins; the last-grant register resets to 1 so   |
// |            channel 0 wins the first tie after reset.                     |
// |   clk, rst_n : clock, synchronous active-low reset                       |
// |   i_req      : per-channel request                                       |
// |   i_update   : commit o_gnt as the new last grant                        |
// |   o_gnt      : granted channel index (valid when o_any)                  |
// |   o_any      : at least one request pending                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module com_spi_rr_arb (
    input  wire        clk,
    input  wire        rst_n,
    input  wire  [1:0] i_req,
    input  wire        i_update,
    output logic       o_gnt,
    output logic       o_any
);

    logic r_last;

    always_comb begin
        o_any = |i_req;
        if (i_req == 2'b11) begin
            o_gnt = ~r_last;
        end else begin
            o_gnt = i_req[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (i_update) begin
            r_last <= o_gnt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/com_spi_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : com_spi_sched                                                 |
// | Purpose  : Shares one COM SPI engine between the host CSR channel (0)    |
// |            and the autoread channel (1). Grants bursts round-robin,      |
// |            streams TX words through an eng_go/eng_done handshake, holds  |
// |            chip-select across a burst, enforces a CS-high gap between    |
// |            bursts and aborts a stuck word with a watchdog.               |
// |   clk, rst_n : clock, synchronous active-low reset                       |
// |   bus        : com_spi_sched_if.slave (requester and engine signals)     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module com_spi_sched
    import com_spi_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 1024
) (
    input  wire             clk,
    input  wire             rst_n,
    com_spi_sched_if.slave  bus
);

    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    sched_state_t r_state;
    sched_state_t w_state_nxt;

    logic              r_gnt;
    logic [LEN_W-1:0]  r_rem;
    logic [WD_W-1:0]   r_wd;
    logic [GAP_W-1:0]  r_gap;

    logic [1:0]        r_ack;
    logic [1:0]        r_rx_valid;
    logic [1:0]        r_done;
    logic [1:0]        r_err;
    logic              r_go;
    logic              r_hold;
    logic [WORD_W-1:0] r_rx_data;
    logic [WORD_W-1:0] r_eng_tx;

    logic              w_arb_gnt;
    logic              w_arb_any;
    logic [LEN_W-1:0]  w_req_len;
    logic [WORD_W-1:0] w_tx_word;
    logic              w_tx_valid;
    logic              w_timeout;

    logic              w_grant;
    logic              w_zero_len;
    logic              w_tx_hs;
    logic              w_word_done;
    logic              w_last_word;
    logic              w_abort;

    com_spi_rr_arb u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (bus.ch_req),
        .i_update (w_grant),
        .o_gnt    (w_arb_gnt),
        .o_any    (w_arb_any)
    );

    // Length of the channel the arbiter is offering; TX word of the
    // channel currently holding the burst.
    assign w_req_len  = (w_arb_gnt == 1'(CH_AUTO)) ? bus.ch_len[2*LEN_W-1:LEN_W]
                                                  : bus.ch_len[LEN_W-1:0];
    assign w_tx_word  = (r_gnt == 1'(CH_AUTO)) ? bus.ch_tx[2*WORD_W-1:WORD_W]
                                              : bus.ch_tx[WORD_W-1:0];
    assign w_tx_valid = bus.ch_tx_valid[r_gnt];
    assign w_timeout  = (r_wd == WD_W'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and per-cycle decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_zero_len  = 1'b0;
        w_tx_hs     = 1'b0;
        w_word_done = 1'b0;
        w_last_word = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_any) begin
                    w_grant = 1'b1;
                    // An empty burst completes immediately without
                    // touching the engine or consuming a gap.
                    if (w_req_len == '0) begin
                        w_zero_len = 1'b1;
                    end else begin
                        w_state_nxt = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (w_tx_valid) begin
                    w_tx_hs     = 1'b1;
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                // A completion landing on the timeout cycle still counts.
                if (bus.eng_done) begin
                    w_word_done = 1'b1;
                    if (r_rem == LEN_W'(1)) begin
                        w_last_word = 1'b1;
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_state_nxt = ST_LOAD;
                    end
                end else if (w_timeout) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap == GAP_W'(GAP_CYCLES - 1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath, counters and registered strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gnt      <= 1'b0;
            r_rem      <= '0;
            r_wd       <= '0;
            r_gap      <= '0;
            r_ack      <= 2'b00;
            r_rx_valid <= 2'b00;
            r_done     <= 2'b00;
            r_err      <= 2'b00;
            r_go       <= 1'b0;
            r_hold     <= 1'b0;
            r_rx_data  <= '0;
            r_eng_tx   <= '0;
        end else begin
            r_ack      <= 2'b00;
            r_rx_valid <= 2'b00;
            r_done     <= 2'b00;
            r_err      <= 2'b00;
            r_go       <= 1'b0;

            if (w_grant) begin
                r_gnt <= w_arb_gnt;
                r_rem <= w_req_len;
                r_ack <= ch_onehot(w_arb_gnt);
                if (w_zero_len) begin
                    r_done <= ch_onehot(w_arb_gnt);
                end else begin
                    r_hold <= 1'b1;
                end
            end

            // Watchdog restarts with the go pulse; its value is 0 in the
            // eng_go cycle and only matters while in XFER.
            if (w_tx_hs) begin
                r_eng_tx <= w_tx_word;
                r_go     <= 1'b1;
                r_wd     <= '0;
            end else if (r_state == ST_XFER) begin
                r_wd <= r_wd + WD_W'(1);
            end

            if (w_word_done) begin
                r_rx_data  <= bus.eng_rx;
                r_rx_valid <= ch_onehot(r_gnt);
                r_rem      <= r_rem - LEN_W'(1);
                if (w_last_word) begin
                    r_done <= ch_onehot(r_gnt);
                    r_hold <= 1'b0;
                end
            end

            if (w_abort) begin
                r_done <= ch_onehot(r_gnt);
                r_err  <= ch_onehot(r_gnt);
                r_hold <= 1'b0;
            end

            if (r_state == ST_GAP) begin
                r_gap <= r_gap + GAP_W'(1);
            end else begin
                r_gap <= '0;
            end
        end
    end

    assign bus.ch_ack      = r_ack;
    assign bus.ch_tx_ready = (r_state == ST_LOAD) ? ch_onehot(r_gnt) : 2'b00;
    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.ch_done     = r_done;
    assign bus.ch_err      = r_err;
    assign bus.eng_tx      = r_eng_tx;
    assign bus.eng_go      = r_go;
    assign bus.eng_hold    = r_hold;

endmodule
`default_nettype wire

// File: tb/tb_com_spi_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_com_spi_sched                                              |
// | Purpose  : Directed self-checking bench for com_spi_sched with a         |
// |            loopback engine model (eng_rx = eng_tx after a latency).      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_com_spi_sched;

    localparam int WORD_W     = 16;
    localparam int LEN_W      = 4;
    localparam int GAP_CYCLES = 4;
    localparam int TIMEOUT    = 64;

    logic clk;
    logic rst_n;

    com_spi_sched_if #(.WORD_W(WORD_W), .LEN_W(LEN_W)) bus ();

    com_spi_sched #(
        .WORD_W     (WORD_W),
        .LEN_W      (LEN_W),
        .GAP_CYCLES (GAP_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor state (updated 1 time unit after each rising edge)
    int          cyc = 0;
    int          go_cnt = 0;
    int          last_go_cyc = 0;
    int          hold_fall = 0;
    logic        prev_hold = 1'b0;
    int          ack_ch_q[$];
    int          ack_cyc_q[$];
    logic [15:0] rx_q[$];
    int          done_ch_q[$];
    int          done_cyc_q[$];
    logic        done_err_q[$];
    logic        done_rxv_q[$];
    logic [15:0] done_rxd_q[$];

    // Engine model controls
    bit          eng_en  = 1'b1;
    int          eng_lat = 2;
    bit          eng_busy = 1'b0;
    int          eng_cnt = 0;
    logic [15:0] eng_word = '0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.eng_go) begin
            go_cnt++;
            last_go_cyc = cyc;
        end
        for (int c = 0; c < 2; c++) begin
            if (bus.ch_ack[c]) begin
                ack_ch_q.push_back(c);
                ack_cyc_q.push_back(cyc);
            end
            if (bus.rx_valid[c]) rx_q.push_back(bus.rx_data);
            if (bus.ch_done[c]) begin
                done_ch_q.push_back(c);
                done_cyc_q.push_back(cyc);
                done_err_q.push_back(bus.ch_err[c]);
                done_rxv_q.push_back(bus.rx_valid[c]);
                done_rxd_q.push_back(bus.rx_data);
            end
        end
        if (prev_hold && !bus.eng_hold) hold_fall++;
        prev_hold = bus.eng_hold;
        // Loopback engine: eng_done eng_lat cycles after the go cycle
        bus.eng_done = 1'b0;
        if (!rst_n) begin
            eng_busy = 1'b0;
        end else begin
            if (eng_busy) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    bus.eng_done = 1'b1;
                    bus.eng_rx   = eng_word;
                    eng_busy     = 1'b0;
                end
            end
            if (bus.eng_go && eng_en) begin
                eng_busy = 1'b1;
                eng_cnt  = eng_lat;
                eng_word = bus.eng_tx;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear();
        go_cnt = 0;
        hold_fall = 0;
        ack_ch_q.delete();
        ack_cyc_q.delete();
        rx_q.delete();
        done_ch_q.delete();
        done_cyc_q.delete();
        done_err_q.delete();
        done_rxv_q.delete();
        done_rxd_q.delete();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic request(input int ch, input int len);
        bit ok = 1'b0;
        bus.ch_len[ch*LEN_W +: LEN_W] = len[LEN_W-1:0];
        bus.ch_req[ch] = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (bus.ch_ack[ch]) ok = 1'b1;
        end
        bus.ch_req[ch] = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ack_wait ch%0d: got no ch_ack, required one within 200 cycles", ch);
        end
    endtask

    task automatic send_word(input int ch, input logic [15:0] w);
        bit ok = 1'b0;
        bus.ch_tx[ch*WORD_W +: WORD_W] = w;
        bus.ch_tx_valid[ch] = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (bus.ch_tx_ready[ch]) ok = 1'b1;
            tick();
        end
        bus.ch_tx_valid[ch] = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL tx_wait ch%0d: got no ch_tx_ready, required one within 300 cycles", ch);
        end
    endtask

    task automatic wait_dones(input int n, input int bound);
        for (int i = 0; i < bound && done_ch_q.size() < n; i++) tick();
        n_tests++;
        if (done_ch_q.size() < n) begin
            n_fail++;
            $display("FAIL done_wait: got %0d ch_done pulses, required %0d within %0d cycles",
                     done_ch_q.size(), n, bound);
        end
    endtask

    task automatic test_reset();
        logic [43:0] outs;
        rst_n = 1'b0;
        repeat (3) tick();
        outs = {bus.ch_ack, bus.ch_tx_ready, bus.rx_valid, bus.ch_done, bus.ch_err,
                bus.eng_go, bus.eng_hold, bus.rx_data, bus.eng_tx};
        n_tests++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", outs);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        clear();
        request(0, 1);
        send_word(0, 16'hA503);
        wait_dones(1, 50);
        n_tests++;
        if (go_cnt !== 1) begin n_fail++; $display("FAIL single_go_cnt: got %0d required 1", go_cnt); end
        n_tests++;
        if (done_ch_q[0] !== 0) begin n_fail++; $display("FAIL single_done_ch: got %0d required 0", done_ch_q[0]); end
        n_tests++;
        if (done_rxv_q[0] !== 1'b1) begin n_fail++; $display("FAIL single_rxv_with_done: got %b required 1", done_rxv_q[0]); end
        n_tests++;
        if (done_rxd_q[0] !== 16'hA503) begin n_fail++; $display("FAIL single_rx_data: got %h required a503", done_rxd_q[0]); end
        n_tests++;
        if (done_err_q[0] !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b required 0", done_err_q[0]); end
        repeat (5) tick();
        n_tests++;
        if (hold_fall !== 1 || bus.eng_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL single_hold_gap: got falls=%0d hold=%b required falls=1 hold=0", hold_fall, bus.eng_hold);
        end
    endtask

    task automatic test_zero_len();
        clear();
        request(0, 0);
        repeat (2) tick();
        n_tests++;
        if (done_ch_q.size() !== 1 || done_ch_q[0] !== 0) begin
            n_fail++;
            $display("FAIL zero_len_done: got %0d dones required 1 on ch0", done_ch_q.size());
        end
        n_tests++;
        if (done_cyc_q[0] - ack_cyc_q[0] > 1 || done_cyc_q[0] < ack_cyc_q[0]) begin
            n_fail++;
            $display("FAIL zero_len_latency: got done-ack=%0d required 0..1", done_cyc_q[0] - ack_cyc_q[0]);
        end
        n_tests++;
        if (go_cnt !== 0 || hold_fall !== 0 || bus.eng_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_engine: got go=%0d falls=%0d required 0 0", go_cnt, hold_fall);
        end
    endtask

    task automatic test_both();
        apply_reset();
        clear();
        fork
            request(0, 1);
            request(1, 1);
            send_word(0, 16'h0A0A);
            send_word(1, 16'h0B0B);
        join
        wait_dones(2, 100);
        n_tests++;
        if (ack_ch_q.size() !== 2 || ack_ch_q[0] !== 0 || ack_ch_q[1] !== 1) begin
            n_fail++;
            $display("FAIL both_order: got %0d acks first=%0d required 2 acks order 0,1", ack_ch_q.size(), ack_ch_q[0]);
        end
        n_tests++;
        if (ack_cyc_q[1] - done_cyc_q[0] !== GAP_CYCLES + 1) begin
            n_fail++;
            $display("FAIL both_gap: got done->ack %0d required %0d", ack_cyc_q[1] - done_cyc_q[0], GAP_CYCLES + 1);
        end
        n_tests++;
        if (done_rxd_q[0] !== 16'h0A0A || done_rxd_q[1] !== 16'h0B0B) begin
            n_fail++;
            $display("FAIL both_rx: got %h %h required 0a0a 0b0b", done_rxd_q[0], done_rxd_q[1]);
        end
        n_tests++;
        if (hold_fall !== 2) begin n_fail++; $display("FAIL both_hold_falls: got %0d required 2", hold_fall); end
    endtask

    task automatic test_alternate();
        clear();
        bus.ch_len[LEN_W-1:0] = 4'd2;
        bus.ch_tx[15:0]  = 16'h0C0C;
        bus.ch_tx[31:16] = 16'h1C1C;
        bus.ch_tx_valid  = 2'b11;
        bus.ch_req[0]    = 1'b1;
        for (int i = 0; i < 50 && ack_ch_q.size() < 1; i++) tick();
        request(1, 1);
        wait_dones(3, 300);
        bus.ch_req[0]   = 1'b0;
        bus.ch_tx_valid = 2'b00;
        n_tests++;
        if (ack_ch_q.size() !== 3 || ack_ch_q[0] !== 0 || ack_ch_q[1] !== 1 || ack_ch_q[2] !== 0) begin
            n_fail++;
            $display("FAIL alt_order: got n=%0d %0d,%0d,%0d required 0,1,0",
                     ack_ch_q.size(), ack_ch_q[0], ack_ch_q[1], ack_ch_q[2]);
        end
        n_tests++;
        if (go_cnt !== 5) begin n_fail++; $display("FAIL alt_go_cnt: got %0d required 5", go_cnt); end
        n_tests++;
        if (done_err_q[0] | done_err_q[1] | done_err_q[2]) begin
            n_fail++;
            $display("FAIL alt_err: got error flag set, required none");
        end
        repeat (GAP_CYCLES + 2) tick();
    endtask

    task automatic test_stall();
        clear();
        request(1, 3);
        send_word(1, 16'h1111);
        repeat (10) tick();
        send_word(1, 16'h2222);
        send_word(1, 16'h3333);
        wait_dones(1, 100);
        n_tests++;
        if (go_cnt !== 3) begin n_fail++; $display("FAIL stall_go_cnt: got %0d required 3", go_cnt); end
        n_tests++;
        if (hold_fall !== 1) begin n_fail++; $display("FAIL stall_hold: got %0d falls required 1", hold_fall); end
        n_tests++;
        if (rx_q.size() !== 3 || rx_q[0] !== 16'h1111 || rx_q[1] !== 16'h2222 || rx_q[2] !== 16'h3333) begin
            n_fail++;
            $display("FAIL stall_rx_seq: got n=%0d %h %h %h required 1111 2222 3333",
                     rx_q.size(), rx_q[0], rx_q[1], rx_q[2]);
        end
        n_tests++;
        if (done_ch_q[0] !== 1 || done_rxv_q[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done: got ch=%0d rxv=%b required ch1 rxv=1", done_ch_q[0], done_rxv_q[0]);
        end
        repeat (GAP_CYCLES + 2) tick();
    endtask

    task automatic test_timeout();
        int td;
        clear();
        eng_en = 1'b0;
        request(0, 2);
        send_word(0, 16'hDEAD);
        wait_dones(1, TIMEOUT + 20);
        td = done_cyc_q[0];
        n_tests++;
        if (done_ch_q[0] !== 0 || done_err_q[0] !== 1'b1 || done_rxv_q[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_flags: got ch=%0d err=%b rxv=%b required 0 1 0", done_ch_q[0], done_err_q[0], done_rxv_q[0]);
        end
        n_tests++;
        if (td - last_go_cyc !== TIMEOUT) begin
            n_fail++;
            $display("FAIL tmo_latency: got %0d cycles required %0d", td - last_go_cyc, TIMEOUT);
        end
        n_tests++;
        if (rx_q.size() !== 0 || go_cnt !== 1) begin
            n_fail++;
            $display("FAIL tmo_dropped: got rx=%0d go=%0d required 0 1", rx_q.size(), go_cnt);
        end
        eng_en = 1'b1;
        clear();
        request(1, 1);
        n_tests++;
        if (ack_cyc_q[0] - td !== GAP_CYCLES + 1) begin
            n_fail++;
            $display("FAIL tmo_to_idle: got done->ack %0d required %0d", ack_cyc_q[0] - td, GAP_CYCLES + 1);
        end
        send_word(1, 16'h7E57);
        wait_dones(1, 50);
        n_tests++;
        if (done_rxd_q[0] !== 16'h7E57 || done_err_q[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_recover: got %h err=%b required 7e57 err=0", done_rxd_q[0], done_err_q[0]);
        end
        repeat (GAP_CYCLES + 2) tick();
        // Completion on the very cycle the watchdog expires: no error
        clear();
        eng_lat = TIMEOUT - 1;
        request(0, 1);
        send_word(0, 16'hBEEF);
        wait_dones(1, TIMEOUT + 20);
        eng_lat = 2;
        n_tests++;
        if (done_err_q[0] !== 1'b0 || done_rxv_q[0] !== 1'b1 || done_rxd_q[0] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL tmo_done_wins: got err=%b rxv=%b rx=%h required 0 1 beef",
                     done_err_q[0], done_rxv_q[0], done_rxd_q[0]);
        end
        repeat (GAP_CYCLES + 2) tick();
    endtask

    task automatic test_reset_mid();
        logic [43:0] outs;
        clear();
        request(0, 3);
        send_word(0, 16'h0001);
        send_word(0, 16'h0002);
        rst_n = 1'b0;
        tick();
        outs = {bus.ch_ack, bus.ch_tx_ready, bus.rx_valid, bus.ch_done, bus.ch_err,
                bus.eng_go, bus.eng_hold, bus.rx_data, bus.eng_tx};
        n_tests++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h required 0", outs);
        end
        n_tests++;
        if (done_ch_q.size() !== 0) begin
            n_fail++;
            $display("FAIL midrst_no_done: got %0d ch_done required 0", done_ch_q.size());
        end
        tick();
        rst_n = 1'b1;
        tick();
        clear();
        request(1, 1);
        send_word(1, 16'h5A5A);
        wait_dones(1, 50);
        n_tests++;
        if (done_ch_q[0] !== 1 || done_rxd_q[0] !== 16'h5A5A || done_err_q[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_fresh: got ch=%0d rx=%h err=%b required 1 5a5a 0",
                     done_ch_q[0], done_rxd_q[0], done_err_q[0]);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.ch_req      = 2'b00;
        bus.ch_len      = '0;
        bus.ch_tx       = '0;
        bus.ch_tx_valid = 2'b00;
        bus.eng_done    = 1'b0;
        bus.eng_rx      = '0;
        test_reset();
        test_single();
        test_zero_len();
        test_both();
        test_alternate();
        test_stall();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion, required finish within 500000 time units");
        $fatal(1);
    end

endmodule
`default_nettype wire
